// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: the M_Ctrl bit map, the
// access-size encoding, the MEM FSM states and a size helper.
package mem_pkg;

  // M_Ctrl bit positions.
  localparam int unsigned MCtrlReadBit     = 0;
  localparam int unsigned MCtrlWriteBit    = 1;
  localparam int unsigned MCtrlSizeLo      = 2;
  localparam int unsigned MCtrlSizeHi      = 3;
  localparam int unsigned MCtrlUnsignedBit = 4;

  // Access size as encoded in M_Ctrl[3:2].
  typedef enum logic [1:0] {
    SizeB = 2'b00,
    SizeH = 2'b01,
    SizeW = 2'b10,
    SizeD = 2'b11
  } mem_size_e;

  // MEM stage FSM states.
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitRsp = 1'b1
  } mem_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(input mem_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory-access stage.
// Store side: byte enables and lane-replicated write data.
// Load side: pick the addressed bytes out of the read word and extend them.
// The offset is always forced to natural alignment for the access size, so a
// request can never straddle the 64-bit word.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 64
) (
  input  logic [$clog2(REG_WIDTH/8)-1:0] offset,
  input  mem_size_e                      size,
  input  logic                           unsigned_ld,
  input  logic [REG_WIDTH-1:0]           store_data,
  input  logic [REG_WIDTH-1:0]           load_word,
  output logic [REG_WIDTH/8-1:0]         wstrb,
  output logic [REG_WIDTH-1:0]           wdata,
  output logic [REG_WIDTH-1:0]           load_data
);

  localparam int unsigned NumBytes = REG_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  logic [OffW-1:0]      mask;
  logic [OffW-1:0]      lane;
  logic [NumBytes-1:0]  strb_base;
  logic [REG_WIDTH-1:0] shifted;

  // Naturally aligned starting lane: clear the low log2(size) offset bits.
  always_comb begin
    mask = OffW'(size_bytes(size) - 32'd1);
    lane = offset & ~mask;
  end

  // Byte enables start at the aligned lane; store data is replicated so that
  // every lane carries the low size bytes of the source register.
  always_comb begin
    strb_base = '0;
    wdata     = store_data;
    unique case (size)
      SizeB: begin
        strb_base = NumBytes'(1);
        wdata     = {NumBytes{store_data[7:0]}};
      end
      SizeH: begin
        strb_base = NumBytes'(3);
        wdata     = {(NumBytes / 2){store_data[15:0]}};
      end
      SizeW: begin
        strb_base = NumBytes'(15);
        wdata     = {(NumBytes / 4){store_data[31:0]}};
      end
      default: begin
        strb_base = '1;
        wdata     = store_data;
      end
    endcase
    wstrb = strb_base << lane;
  end

  // Bring the addressed lane down to bit 0, then zero- or sign-extend.
  always_comb begin
    shifted = load_word >> {lane, 3'b000};
    unique case (size)
      SizeB:   load_data = {{(REG_WIDTH - 8){~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SizeH:   load_data = {{(REG_WIDTH - 16){~unsigned_ld & shifted[15]}}, shifted[15:0]};
      SizeW:   load_data = {{(REG_WIDTH - 32){~unsigned_ld & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues load/store requests on a valid/ready memory port,
// waits for read responses, and registers the MEM/WB slot. While the stage is
// stalled it holds upstream and pushes a bubble (valid_out=0) into MEM/WB.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses issue no request,
// complete in one cycle and raise the registered misalign_o flag. Without it,
// misaligned offsets are silently forced to natural alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 64,
  parameter int unsigned REG_WIDTH    = 64,
  parameter int unsigned M_Ctrl_bits  = 5,
  parameter int unsigned WB_Ctrl_bits = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WB_Ctrl_bits-1:0]      WB_Ctrl_in,
  input  logic [M_Ctrl_bits-1:0]       M_Ctrl_in,
  input  logic [PC_WIDTH-1:0]          PC_in,
  input  logic [REG_WIDTH-1:0]         ALU_res_in,
  input  logic [REG_WIDTH-1:0]         rs2_data_in,
  input  logic [$clog2(REG_WIDTH)-1:0] rd_addr_in,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic                         req_we,
  output logic [REG_WIDTH-1:0]         req_addr,
  output logic [REG_WIDTH-1:0]         req_wdata,
  output logic [REG_WIDTH/8-1:0]       req_wstrb,
  input  logic                         rsp_valid,
  input  logic [REG_WIDTH-1:0]         rsp_rdata,
  output logic                         stall_o,
  output logic [WB_Ctrl_bits-1:0]      WB_Ctrl_out,
  output logic [PC_WIDTH-1:0]          PC_out,
  output logic [REG_WIDTH-1:0]         ALU_res_out,
  output logic [REG_WIDTH-1:0]         mem_data_out,
  output logic [$clog2(REG_WIDTH)-1:0] rd_addr_out,
  output logic                         valid_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                         misalign_o
`endif
);

  localparam int unsigned NumBytes = REG_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  mem_state_e state_q, state_d;

  logic            is_rd;
  logic            is_wr;
  logic            is_mem;
  logic            unsigned_ld;
  mem_size_e       size;
  logic [OffW-1:0] offset;
  logic            trap;
  logic            load_en;
  logic            take_rsp;

  logic [REG_WIDTH-1:0] load_data;

  // Decode M_Ctrl; a request with both read and write set is a write.
  assign is_rd       = M_Ctrl_in[MCtrlReadBit];
  assign is_wr       = M_Ctrl_in[MCtrlWriteBit];
  assign is_mem      = is_rd | is_wr;
  assign unsigned_ld = M_Ctrl_in[MCtrlUnsignedBit];
  assign size        = mem_size_e'(M_Ctrl_in[MCtrlSizeHi:MCtrlSizeLo]);
  assign offset      = ALU_res_in[OffW-1:0];

`ifdef MISALIGN_TRAP_EN
  logic [OffW-1:0] size_mask;
  logic            misaligned;

  // Any offset bit below the natural alignment of the size is a misalignment.
  always_comb begin
    size_mask  = OffW'(size_bytes(size) - 32'd1);
    misaligned = |(offset & size_mask);
    trap       = is_mem & misaligned;
  end
`else
  assign trap = 1'b0;
`endif

  // Request fields are word-aligned; steering happens in the lane aligner.
  assign req_addr = {ALU_res_in[REG_WIDTH-1:OffW], OffW'(0)};
  assign req_we   = req_valid & is_wr;

  mem_lane_align #(
    .REG_WIDTH(REG_WIDTH)
  ) u_lane_align (
    .offset     (offset),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .store_data (rs2_data_in),
    .load_word  (rsp_rdata),
    .wstrb      (req_wstrb),
    .wdata      (req_wdata),
    .load_data  (load_data)
  );

  // Next state, request/stall outputs and the MEM/WB load enable.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    stall_o   = 1'b0;
    load_en   = 1'b0;
    take_rsp  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!is_mem || trap) begin
          load_en = 1'b1;
        end else begin
          req_valid = 1'b1;
          if (is_wr) begin
            // Stores retire on the handshake itself.
            if (req_ready) begin
              load_en = 1'b1;
            end else begin
              stall_o = 1'b1;
            end
          end else begin
            // Loads always stall here; the data comes back later.
            stall_o = 1'b1;
            if (req_ready) begin
              state_d = StWaitRsp;
            end
          end
        end
      end
      StWaitRsp: begin
        if (rsp_valid) begin
          load_en  = 1'b1;
          take_rsp = 1'b1;
          state_d  = StIdle;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Keep the memory port and upstream quiet while in reset.
    if (rst) begin
      req_valid = 1'b0;
      stall_o   = 1'b0;
    end
  end

  // FSM state register; reset abandons any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // MEM/WB register: load on completion, otherwise insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_Ctrl_out  <= '0;
      PC_out       <= '0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
      rd_addr_out  <= '0;
      valid_out    <= 1'b0;
    end else if (load_en) begin
      WB_Ctrl_out  <= WB_Ctrl_in;
      PC_out       <= PC_in;
      ALU_res_out  <= ALU_res_in;
      mem_data_out <= take_rsp ? load_data : '0;
      rd_addr_out  <= rd_addr_in;
      valid_out    <= 1'b1;
    end else begin
      valid_out    <= 1'b0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Trap flag travels with the MEM/WB slot that reports it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= load_en & trap;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a random
// stream of operations checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  WB_Ctrl_in;
  logic [4:0]  M_Ctrl_in;
  logic [63:0] PC_in;
  logic [63:0] ALU_res_in;
  logic [63:0] rs2_data_in;
  logic [5:0]  rd_addr_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        stall_o;
  logic [4:0]  WB_Ctrl_out;
  logic [63:0] PC_out;
  logic [63:0] ALU_res_out;
  logic [63:0] mem_data_out;
  logic [5:0]  rd_addr_out;
  logic        valid_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int total = 0;
  int bad   = 0;

  int          last_stalls;
  int          last_reqs;
  logic [7:0]  last_wstrb;
  logic [63:0] last_wdata;
  logic [63:0] last_addr;

  mem_access_unit #(
    .PC_WIDTH    (64),
    .REG_WIDTH   (64),
    .M_Ctrl_bits (5),
    .WB_Ctrl_bits(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WB_Ctrl_in  (WB_Ctrl_in),
    .M_Ctrl_in   (M_Ctrl_in),
    .PC_in       (PC_in),
    .ALU_res_in  (ALU_res_in),
    .rs2_data_in (rs2_data_in),
    .rd_addr_in  (rd_addr_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .stall_o     (stall_o),
    .WB_Ctrl_out (WB_Ctrl_out),
    .PC_out      (PC_out),
    .ALU_res_out (ALU_res_out),
    .mem_data_out(mem_data_out),
    .rd_addr_out (rd_addr_out),
    .valid_out   (valid_out)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain byte arithmetic on the access rules ----
  function automatic int model_off(input logic [63:0] addr, input int nb);
    int o;
    o = int'(addr % 64'd8);
    return o - (o % nb);
  endfunction

  function automatic logic [63:0] byte_mask(input int nb);
    if (nb >= 8) return {64{1'b1}};
    return (64'd1 << (8 * nb)) - 64'd1;
  endfunction

  function automatic logic [7:0] model_strb(input logic [63:0] addr, input int nb);
    int s;
    s = ((1 << nb) - 1) << model_off(addr, nb);
    return 8'(s);
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input int nb);
    logic [63:0] chunk, r;
    chunk = d & byte_mask(nb);
    r = '0;
    for (int k = 0; k < 8 / nb; k++) r = r | (chunk << (8 * nb * k));
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] word, input logic [63:0] addr,
                                             input int nb, input logic uns);
    logic [63:0] v, m;
    m = byte_mask(nb);
    v = (word >> (8 * model_off(addr, nb))) & m;
    if (!uns && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0)) v = v | ~m;
    return v;
  endfunction

  // One operation from presentation to MEM/WB. Entered and left at posedge+1.
  // rdy_dly: cycles req_ready stays low; rsp_dly: empty wait cycles before rsp.
  task automatic run_op(input logic [4:0] mc, input logic [63:0] addr, input logic [63:0] rs2,
                        input int rdy_dly, input int rsp_dly, input logic [63:0] rdata,
                        input logic rsp_noise);
    logic        wr, rd_op, is_mem, trap;
    int          nb, last;
    logic [4:0]  wb;
    logic [63:0] pc;
    logic [5:0]  rdst;
    logic [63:0] exp_data;
    wb     = 5'($urandom);
    pc     = {$urandom, $urandom};
    rdst   = 6'($urandom);
    wr     = mc[1];
    rd_op  = mc[0] & ~mc[1];
    is_mem = wr | rd_op;
    nb     = 1 << mc[3:2];
    trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = is_mem && ((addr % 64'(nb)) != 64'd0);
`endif
    if (!is_mem || trap) last = 0;
    else if (wr)         last = rdy_dly;
    else                 last = rdy_dly + 1 + rsp_dly;

    M_Ctrl_in   = mc;
    ALU_res_in  = addr;
    rs2_data_in = rs2;
    WB_Ctrl_in  = wb;
    PC_in       = pc;
    rd_addr_in  = rdst;
    last_stalls = 0;
    last_reqs   = 0;

    for (int c = 0; c <= last; c++) begin
      req_ready = (c == rdy_dly);
      rsp_valid = rd_op && !trap && (c == last);
      if (rsp_noise && c <= rdy_dly) rsp_valid = 1'b1;
      rsp_rdata = (rd_op && c == last) ? rdata : {$urandom, $urandom};
      #4;
      if (stall_o) last_stalls++;
      chk("stall_o", stall_o, c != last);
      if (is_mem && !trap && c <= rdy_dly) begin
        last_reqs++;
        last_addr  = req_addr;
        last_wstrb = req_wstrb;
        last_wdata = req_wdata;
        chk("req_valid", req_valid, 1'b1);
        chk("req_addr", req_addr, {addr[63:3], 3'b000});
        chk("req_we", req_we, wr);
        if (wr) begin
          chk("req_wstrb", req_wstrb, model_strb(addr, nb));
          chk("req_wdata", req_wdata, model_wdata(rs2, nb));
        end
      end else begin
        chk("req_idle", req_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      if (c < last) chk("bubble", valid_out, 1'b0);
    end

    exp_data = (rd_op && !trap) ? model_load(rdata, addr, nb, mc[4]) : 64'd0;
    chk("valid_out", valid_out, 1'b1);
    chk("WB_Ctrl_out", WB_Ctrl_out, wb);
    chk("PC_out", PC_out, pc);
    chk("ALU_res_out", ALU_res_out, addr);
    chk("rd_addr_out", rd_addr_out, rdst);
    chk("mem_data_out", mem_data_out, exp_data);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_o", misalign_o, trap);
`endif
    rsp_valid = 1'b0;
    req_ready = 1'b0;
  endtask

  initial begin
    // Reset with a load presented and the port ready: nothing may leave.
    rst         = 1'b1;
    M_Ctrl_in   = 5'b01001;
    WB_Ctrl_in  = 5'h1f;
    PC_in       = 64'h4000;
    ALU_res_in  = 64'h3008;
    rs2_data_in = 64'h55;
    rd_addr_in  = 6'd7;
    req_ready   = 1'b1;
    rsp_valid   = 1'b1;
    rsp_rdata   = 64'hdead_beef;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_alu_out", ALU_res_out, 64'd0);
    chk("rst_mem_data", mem_data_out, 64'd0);
    chk("rst_pc_out", PC_out, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_valid = 1'b0;

    // Non-memory op passes straight through.
    run_op(5'b00000, 64'h1234, 64'd0, 0, 0, 64'd0, 1'b0);
    chk("alu_pass", ALU_res_out, 64'h1234);
    chk("alu_stalls", last_stalls, 0);

    // SB at byte lane 3, accepted at once.
    run_op(5'b00010, 64'h1003, 64'hAB, 0, 0, 64'd0, 1'b0);
    chk("sb_wstrb", last_wstrb, 8'h08);
    chk("sb_wdata", last_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    chk("sb_stalls", last_stalls, 0);

    // Signed LH at lane 6, response after three empty wait cycles.
    run_op(5'b00101, 64'h2006, 64'd0, 0, 3, 64'h8001_0000_0000_0000, 1'b0);
    chk("lh_stalls", last_stalls, 4);
    chk("lh_data", mem_data_out, 64'hFFFF_FFFF_FFFF_8001);

    // LW with the port busy for two cycles, stray rsp_valid while idle.
    run_op(5'b01001, 64'h2010, 64'd0, 2, 1, 64'h0000_0000_7654_3210, 1'b1);
    chk("lw_bp_stalls", last_stalls, 4);
    chk("lw_bp_reqs", last_reqs, 3);
    chk("lw_bp_data", mem_data_out, 64'h7654_3210);

    // LBU from the top lane.
    run_op(5'b10001, 64'h5007, 64'd0, 0, 0, 64'hF000_0000_0000_0000, 1'b0);
    chk("lbu_data", mem_data_out, 64'hF0);

    // Misaligned LW at offset 2.
    run_op(5'b01001, 64'h2002, 64'd0, 0, 0, 64'h1111_2222_8765_4321, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_reqs", last_reqs, 0);
    chk("mis_data", mem_data_out, 64'd0);
`else
    chk("mis_addr", last_addr, 64'h2000);
    chk("mis_data", mem_data_out, 64'hFFFF_FFFF_8765_4321);
`endif

    // Reset while a read is outstanding; its late response must be ignored.
    M_Ctrl_in  = 5'b01001;
    ALU_res_in = 64'h3000;
    req_ready  = 1'b1;
    rsp_valid  = 1'b0;
    @(posedge clk);
    #1;
    #4;
    chk("wait_req_valid", req_valid, 1'b0);
    chk("wait_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_stall", stall_o, 1'b0);
    chk("arst_alu_out", ALU_res_out, 64'd0);
    chk("arst_pc_out", PC_out, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'hCAFE_F00D;
    #4;
    chk("post_rst_idle_req", req_valid, 1'b1);
    chk("post_rst_stall", stall_o, 1'b1);
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    chk("late_rsp_valid_out", valid_out, 1'b0);
    chk("late_rsp_mem_data", mem_data_out, 64'd0);
    chk("late_rsp_alu_out", ALU_res_out, 64'd0);
    chk("late_rsp_wb_out", WB_Ctrl_out, 5'd0);
    #4;
    chk("late_rsp_still_idle", req_valid, 1'b1);
    @(posedge clk);
    #1;

    // Random stream against the model.
    for (int n = 0; n < 60; n++) begin
      run_op(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 64, giving the PC width.
REQ-002 The block SHALL have parameter REG_WIDTH, default 64, giving the datapath and memory word width.
REQ-003 The block SHALL have parameter M_Ctrl_bits, default 5, giving the memory-control width.
REQ-004 The block SHALL have parameter WB_Ctrl_bits, default 5, giving the writeback-control width.
REQ-005 The ports SHALL be as follows, one clock, with reset asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  async active-high reset
- WB_Ctrl_in  in  WB_Ctrl_bits  writeback control from EX/MEM
- M_Ctrl_in  in  M_Ctrl_bits  memory control from EX/MEM
- PC_in  in  PC_WIDTH  instruction PC
- ALU_res_in  in  REG_WIDTH  effective address or ALU result
- rs2_data_in  in  REG_WIDTH  store data
- rd_addr_in  in  $clog2(REG_WIDTH)  destination register
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  request is a write
- req_addr  out  REG_WIDTH  word-aligned address (low 3 bits zero)
- req_wdata  out  REG_WIDTH  lane-replicated store data
- req_wstrb  out  REG_WIDTH/8  byte enables
- rsp_valid  in  1  read data valid
- rsp_rdata  in  REG_WIDTH  read word
- stall_o  out  1  hold EX/MEM and upstream stages
- WB_Ctrl_out  out  WB_Ctrl_bits  registered to MEM/WB
- PC_out  out  PC_WIDTH  registered PC
- ALU_res_out  out  REG_WIDTH  registered ALU result
- mem_data_out  out  REG_WIDTH  registered, extended load data
- rd_addr_out  out  $clog2(REG_WIDTH)  registered destination
- valid_out  out  1  MEM/WB slot holds a real instruction

Function
REQ-006 M_Ctrl_in decoding SHALL be: bit0 read, bit1 write, bits[3:2] size (00 B, 01 H, 10 W, 11 D), bit4 unsigned load.
REQ-007 If both read and write are set, the operation SHALL be treated as a write.
REQ-008 The FSM SHALL have two states: IDLE and WAIT_RSP.
REQ-009 A non-memory op in IDLE SHALL load all outputs at the next edge with valid_out=1, stall_o=0, and mem_data_out=0.
REQ-010 A memory op in IDLE SHALL drive req_valid=1 combinationally in the same cycle, with req_addr equal to ALU_res_in with bits[2:0] cleared.
REQ-011 A write SHALL complete on the cycle where req_valid&&req_ready: stall_o=0 in that cycle, and outputs load at the edge.
REQ-012 A read that handshakes SHALL move to WAIT_RSP, with stall_o=1 in that cycle.
REQ-013 In WAIT_RSP, req_valid SHALL be 0, and stall_o SHALL be 1 until the rsp_valid cycle.
REQ-014 In the rsp_valid cycle, stall_o SHALL be 0, outputs SHALL load, and the FSM SHALL return to IDLE.
REQ-015 While stall_o=1, valid_out SHALL be set to 0 at each edge, inserting a bubble.
REQ-016 The inputs SHALL be held stable by upstream while stall_o=1.
REQ-017 req_wstrb SHALL enable size-many bytes starting at lane ALU_res_in[2:0].
REQ-018 req_wdata SHALL replicate the low size bytes of rs2_data_in across all lanes.
REQ-019 Load data SHALL take the bytes of rsp_rdata at offset ALU_res_in[2:0] and extend them to REG_WIDTH, zero-extended if bit4 is set and sign-extended otherwise; D loads SHALL pass through.
REQ-020 rsp_valid SHALL be ignored while in IDLE.
REQ-021 An address offset plus size that exceeds 8 bytes SHALL be handled per REQ-025 and REQ-026.

Reset
REQ-022 On rst, the FSM SHALL go to IDLE and every registered output SHALL be set to 0, including valid_out.
REQ-023 req_valid and stall_o SHALL be 0 while rst is high.
REQ-024 A read outstanding at reset SHALL be abandoned, and its late rsp_valid SHALL be ignored.

Configuration
REQ-025 With MISALIGN_TRAP_EN defined, a misaligned access SHALL issue no request, SHALL complete in one cycle with valid_out=1, and SHALL assert an extra output misalign_o (1 bit, registered, reset 0) alongside it.
REQ-026 Without MISALIGN_TRAP_EN, the offset SHALL be forced to natural alignment (low log2(size) bits cleared), and misalign_o SHALL be absent.

Structure
REQ-027 The M_Ctrl bit positions, the size encoding and the FSM state enum SHALL live in a shared package, mem_pkg.
REQ-028 Lane steering and extension SHALL be a combinational sub-module, mem_lane_align.

Verification
REQ-029 Non-memory op, ALU_res_in=0x1234 -> one cycle later ALU_res_out=0x1234, valid_out=1, stall_o never 1.
REQ-030 SB with addr 0x1003, rs2=0xAB, req_ready=1 immediately -> req_wstrb=0x08, req_wdata=0xABAB...AB, zero stall cycles.
REQ-031 LH signed, addr 0x2006, rsp_rdata=0x8001_0000_0000_0000, rsp after 3 cycles -> stall_o high for 4 cycles, mem_data_out=0xFFFF_FFFF_FFFF_8001.
REQ-032 LW with req_ready low for 2 cycles -> req_valid and req_addr held stable, and no bubble is lost or duplicated.
REQ-033 rst asserted in WAIT_RSP, then rsp_valid pulsed after release -> all outputs 0 and FSM in IDLE.
REQ-034 Misaligned LW at 0x2002 -> with the macro, misalign_o=1 and no req_valid; without it, req_addr=0x2000 and data is taken from lane 0.
